// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator with a 2-entry skid buffer and valid/ready handshake.
// Optional macro IMM_ERR_CNT_EN adds a saturating 16-bit reserved-encoding counter (err_cnt).
module imm_gen_pipe #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_out,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
`ifdef IMM_ERR_CNT_EN
  ,
  output logic [15:0]      err_cnt
`endif
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t state, state_nxt;

  // Raw 32-bit immediate; every format except Z is built as a signed value from instr[31].
  function automatic logic signed [31:0] gen_imm(input logic [31:0] ins, input logic [2:0] src);
    logic signed [31:0] r;
    case (src)
      3'b000:  r = {{20{ins[31]}}, ins[31:20]};
      3'b001:  r = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      3'b010:  r = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      3'b011:  r = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      3'b100:  r = {ins[31:12], 12'b0};
      3'b101:  r = {27'b0, ins[19:15]};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic signed [31:0]      imm32_p0;
  logic signed [XLEN-1:0]  imm_p0;
  logic                    err_p0;
  logic                    unused_opcode;

  assign imm32_p0      = gen_imm(instr, imm_src);
  assign err_p0        = imm_src[2] & imm_src[1];
  assign unused_opcode = ^instr[6:0];

  // Z is zero in the upper bits already, so sign-extending imm32 is correct for all formats.
  if (XLEN > 32) begin : g_ext
    assign imm_p0 = {{(XLEN-32){imm32_p0[31]}}, imm32_p0};
  end else begin : g_trunc
    assign imm_p0 = imm32_p0[XLEN-1:0];
  end

  // ---- p0 -> p1: head / skid storage ----
  logic signed [XLEN-1:0]  head_imm_p1, skid_imm_p1;
  logic [TAG_W-1:0]        head_tag_p1, skid_tag_p1;
  logic                    head_err_p1, skid_err_p1;
  logic                    acc, pop;
  logic                    load_head, load_skid, head_from_skid;

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign acc       = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_nxt      = state;
    load_head      = 1'b0;
    load_skid      = 1'b0;
    head_from_skid = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (acc) begin
          state_nxt = ONE;
          load_head = 1'b1;
        end
        ONE: begin
          if (acc && !pop) begin
            state_nxt = TWO;
            load_skid = 1'b1;
          end else if (acc && pop) begin
            load_head = 1'b1;
          end else if (pop) begin
            state_nxt = EMPTY;
          end
        end
        TWO: if (pop) begin
          state_nxt      = ONE;
          head_from_skid = 1'b1;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // Data is reset too so the outputs read zero while the block is held in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_imm_p1 <= '0;
      head_tag_p1 <= '0;
      head_err_p1 <= 1'b0;
      skid_imm_p1 <= '0;
      skid_tag_p1 <= '0;
      skid_err_p1 <= 1'b0;
    end else begin
      if (load_head) begin
        head_imm_p1 <= imm_p0;
        head_tag_p1 <= in_tag;
        head_err_p1 <= err_p0;
      end else if (head_from_skid) begin
        head_imm_p1 <= skid_imm_p1;
        head_tag_p1 <= skid_tag_p1;
        head_err_p1 <= skid_err_p1;
      end
      if (load_skid) begin
        skid_imm_p1 <= imm_p0;
        skid_tag_p1 <= in_tag;
        skid_err_p1 <= err_p0;
      end
    end
  end

  assign imm_out = head_imm_p1;
  assign out_tag = head_tag_p1;
  assign out_err = head_err_p1;

`ifdef IMM_ERR_CNT_EN
  // Counted at accept time, so an entry that is later flushed still counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             err_cnt <= '0;
    else if (acc && err_p0) err_cnt <= sat_inc(err_cnt);
  end
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=64 and XLEN=32 instances share one stimulus.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] instr;
  logic [2:0]  imm_src;
  logic [7:0]  in_tag;

  logic        in_ready, out_valid, out_err;
  logic [63:0] imm_out;
  logic [7:0]  out_tag;
  logic        in_ready32, out_valid32, out_err32;
  logic [31:0] imm_out32;
  logic [7:0]  out_tag32;
`ifdef IMM_ERR_CNT_EN
  logic [15:0] err_cnt, err_cnt32;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .imm_src(imm_src), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .imm_out(imm_out), .out_tag(out_tag), .out_err(out_err)
`ifdef IMM_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .imm_src(imm_src), .in_tag(in_tag), .out_valid(out_valid32),
    .out_ready(out_ready), .imm_out(imm_out32), .out_tag(out_tag32), .out_err(out_err32)
`ifdef IMM_ERR_CNT_EN
    , .err_cnt(err_cnt32)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  src;
    logic [7:0]  tag;
    logic [63:0] exp64;
    logic [31:0] exp32;
    logic        err;
  } vec_t;

  vec_t vecs[12];

  task automatic push(input logic [31:0] i, input logic [2:0] s, input logic [7:0] t);
    instr    = i;
    imm_src  = s;
    in_tag   = t;
    in_valid = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{32'hFFF00093, 3'b000, 8'h01, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    vecs[1]  = '{32'h7FF00093, 3'b000, 8'h02, 64'h0000_0000_0000_07FF, 32'h0000_07FF, 1'b0};
    vecs[2]  = '{32'hFE112E23, 3'b001, 8'h03, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC, 1'b0};
    vecs[3]  = '{32'hFE000EE3, 3'b010, 8'h04, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC, 1'b0};
    vecs[4]  = '{32'h00000863, 3'b010, 8'h05, 64'h0000_0000_0000_0010, 32'h0000_0010, 1'b0};
    vecs[5]  = '{32'h0010006F, 3'b011, 8'h06, 64'h0000_0000_0000_0800, 32'h0000_0800, 1'b0};
    vecs[6]  = '{32'h8000006F, 3'b011, 8'h07, 64'hFFFF_FFFF_FFF0_0000, 32'hFFF0_0000, 1'b0};
    vecs[7]  = '{32'h123450B7, 3'b100, 8'h08, 64'h0000_0000_1234_5000, 32'h1234_5000, 1'b0};
    vecs[8]  = '{32'h80000037, 3'b100, 8'h09, 64'hFFFF_FFFF_8000_0000, 32'h8000_0000, 1'b0};
    vecs[9]  = '{32'hFFFFF073, 3'b101, 8'h0A, 64'h0000_0000_0000_001F, 32'h0000_001F, 1'b0};
    vecs[10] = '{32'hFFFFFFFF, 3'b110, 8'h0B, 64'h0,                   32'h0,           1'b1};
    vecs[11] = '{32'hFFFFFFFF, 3'b111, 8'h0C, 64'h0,                   32'h0,           1'b1};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instr = '0; imm_src = '0; in_tag = '0;
    repeat (2) @(negedge clk);
    chk("reset_out_valid", {63'b0, out_valid}, 64'd0);
    chk("reset_in_ready", {63'b0, in_ready}, 64'd1);
    chk("reset_in_ready32", {63'b0, in_ready32}, 64'd1);
    chk("reset_imm", imm_out, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 12; k++) begin
      push(vecs[k].instr, vecs[k].src, vecs[k].tag);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("v%0d_valid", k), {63'b0, out_valid}, 64'd1);
      chk($sformatf("v%0d_imm64", k), imm_out, vecs[k].exp64);
      chk($sformatf("v%0d_tag", k), {56'b0, out_tag}, {56'b0, vecs[k].tag});
      chk($sformatf("v%0d_err", k), {63'b0, out_err}, {63'b0, vecs[k].err});
      chk($sformatf("v%0d_valid32", k), {63'b0, out_valid32}, 64'd1);
      chk($sformatf("v%0d_imm32", k), {32'b0, imm_out32}, {32'b0, vecs[k].exp32});
      chk($sformatf("v%0d_tag32", k), {56'b0, out_tag32}, {56'b0, vecs[k].tag});
      chk($sformatf("v%0d_err32", k), {63'b0, out_err32}, {63'b0, vecs[k].err});
    end
    @(negedge clk);
    chk("drain_empty", {63'b0, out_valid}, 64'd0);
`ifdef IMM_ERR_CNT_EN
    chk("err_cnt_two", {48'b0, err_cnt}, 64'd2);
    chk("err_cnt32_two", {48'b0, err_cnt32}, 64'd2);
`endif

    // Backpressure: three pushes against a stalled consumer.
    out_ready = 1'b0;
    push(32'hFFF00093, 3'b000, 8'd1);
    @(negedge clk);
    chk("bp_ready_after1", {63'b0, in_ready}, 64'd1);
    chk("bp_tag_after1", {56'b0, out_tag}, 64'd1);
    push(32'h123450B7, 3'b100, 8'd2);
    @(negedge clk);
    chk("bp_ready_after2", {63'b0, in_ready}, 64'd0);
    chk("bp_tag_after2", {56'b0, out_tag}, 64'd1);
    push(32'h0010006F, 3'b011, 8'd3);
    @(negedge clk);
    chk("bp_ready_held", {63'b0, in_ready}, 64'd0);
    chk("bp_tag_held", {56'b0, out_tag}, 64'd1);
    chk("bp_imm_stable", imm_out, 64'hFFFF_FFFF_FFFF_FFFF);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_tag2", {56'b0, out_tag}, 64'd2);
    chk("bp_imm2", imm_out, 64'h0000_0000_1234_5000);
    chk("bp_ready_reopen", {63'b0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_tag3", {56'b0, out_tag}, 64'd3);
    chk("bp_imm3", imm_out, 64'h0000_0000_0000_0800);
    chk("bp_valid3", {63'b0, out_valid}, 64'd1);
    @(negedge clk);
    chk("bp_drained", {63'b0, out_valid}, 64'd0);

    // Flush in TWO with a concurrent input.
    out_ready = 1'b0;
    push(32'h00100093, 3'b000, 8'd10);
    @(negedge clk);
    push(32'h00200093, 3'b000, 8'd11);
    @(negedge clk);
    chk("fl_two_ready", {63'b0, in_ready}, 64'd0);
    push(32'h00300093, 3'b000, 8'd12);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_two_valid", {63'b0, out_valid}, 64'd0);
    chk("fl_two_ready_after", {63'b0, in_ready}, 64'd1);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("fl_two_nothing", {63'b0, out_valid}, 64'd0);

    // Flush in ONE discards an input accepted in the same cycle.
    out_ready = 1'b0;
    push(32'h00100093, 3'b000, 8'd20);
    @(negedge clk);
    push(32'h00500093, 3'b000, 8'd21);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_one_valid", {63'b0, out_valid}, 64'd0);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("fl_one_nothing", {63'b0, out_valid}, 64'd0);
`ifdef IMM_ERR_CNT_EN
    chk("err_cnt_after_flush", {48'b0, err_cnt}, 64'd2);
`endif

    // Asynchronous reset with a reserved entry held at the output.
    out_ready = 1'b0;
    push(32'hFFF00093, 3'b110, 8'hAB);
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst_pre_err", {63'b0, out_err}, 64'd1);
    chk("rst_pre_tag", {56'b0, out_tag}, 64'hAB);
    push(32'hFFF00093, 3'b000, 8'hCD);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_mid_ready", {63'b0, in_ready}, 64'd1);
    chk("rst_mid_imm", imm_out, 64'd0);
    chk("rst_mid_tag", {56'b0, out_tag}, 64'd0);
    chk("rst_mid_err", {63'b0, out_err}, 64'd0);
`ifdef IMM_ERR_CNT_EN
    chk("rst_mid_err_cnt", {48'b0, err_cnt}, 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", {63'b0, out_valid}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined immediate generator for the decode stage. It supersedes the purely combinational I/S/B/J extractor with the following additions:
- XLEN-generic output (32 or 64).
- U-type and CSR zimm formats.
- Reserved-encoding error flag.
- valid/ready handshake with a 2-entry skid buffer, giving full throughput under backpressure.
It sits between the fetch/decode boundary and the register-read stage. A side-band tag (PC index / ROB id) travels with each immediate.

Parameters:
XLEN, 64, output datapath width; only 32 and 64 are legal.
TAG_W, 8, width of the pass-through tag.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  reset, asynchronous, active-low.
flush  in  1  synchronous pipeline flush.
in_valid  in  1  input transfer valid.
in_ready  out  1  block can accept; = (count != 2), derived from registers only.
instr  in  32  raw instruction word.
imm_src  in  3  000 I, 001 S, 010 B, 011 J, 100 U, 101 Z (CSR zimm), 110/111 reserved.
in_tag  in  TAG_W  side-band tag.
out_valid  out  1  output entry valid.
out_ready  in  1  consumer accepts.
imm_out  out  XLEN  extended immediate.
out_tag  out  TAG_W  tag of the output entry.
out_err  out  1  entry had a reserved imm_src.

Behaviour:
- Handshakes: input accepts when in_valid && in_ready; output transfers when out_valid && out_ready.
- Immediate formats (all sign-extend from instr[31] to XLEN):
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - U: {instr[31:12], 12'b0}.
- Z: zero-extend instr[19:15].
- Reserved imm_src: imm = 0, err = 1. All other formats: err = 0.
- Storage: two entries, head (drives outputs) and skid, each holding {imm, tag, err}. State is count ∈ {0 EMPTY, 1 ONE, 2 TWO}.
- Latency: an item accepted at edge N appears on the outputs after edge N; out_valid is high in cycle N+1. No combinational path from in_* to out_*.
- Transitions per edge, with acc = in accept and pop = out transfer:
  - EMPTY: acc → ONE (head loads input).
  - ONE: acc && !pop → TWO (skid loads input). acc && pop → ONE (head loads input). !acc && pop → EMPTY.
  - TWO: in_ready = 0. pop → ONE (head loads skid).
- Ordering: strict FIFO; an item never overtakes another.
- Output stability: while out_valid && !out_ready, imm_out, out_tag and out_err stay stable.
- Flush: sets count = 0 on the next edge and discards any input accepted in the same cycle. Flush has priority over accept and pop.
- Reset (async assert, sync-safe release): count = 0, out_valid = 0, imm_out = 0, out_tag = 0, out_err = 0. in_ready reads 1 while in reset and after it.
- XLEN = 32: the same formats, truncated to 32 bits with no extension. U gives {instr[31:12], 12'b0} exactly.

Optional Feature:
Macro: IMM_ERR_CNT_EN.
- Defined: adds output port err_cnt, 16 bits, and a counter behind it.
  - Increments on each accepted input with reserved imm_src, and saturates at 0xFFFF.
  - Resets to 0 on rst_n only; flush does not clear it.
  - Counts at accept, even if the entry is later flushed.
- Undefined: neither the port nor the counter exists; all other behaviour is identical.

Test Plan:
- XLEN=64, instr 0xFFF00093, imm_src 000, out_ready=1 → next cycle imm_out = 0xFFFFFFFFFFFFFFFF, out_err = 0, out_tag echoes in_tag.
- instr 0xFE000EE3 / B → 0xFFFFFFFFFFFFFFFC; instr 0x0010006F / J → 0x0000000000000800.
- instr 0x123450B7 / U → 0x0000000012345000; instr 0x80000037 / U → 0xFFFFFFFF80000000; with XLEN=32 → 0x80000000.
- Backpressure:
  - Stimulus: out_ready=0, push tags 1, 2, 3 on consecutive cycles.
  - During stall: in_ready drops to 0 after 2 accepts; tag 3 is held at the input, and outputs stay at tag 1.
  - After out_ready=1: tags 1, 2, 3 emerge in consecutive cycles.
- TWO state, flush=1 with in_valid=1 in the same cycle → next cycle out_valid = 0, in_ready = 1, and the flushed-cycle input never appears.
- imm_src 110 and 111, one each → imm_out = 0, out_err = 1. With IMM_ERR_CNT_EN: err_cnt = 2, and it remains 2 after a flush. rst_n low mid-stream → all outputs 0 immediately.
